// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared widths, constants and output-register record for the
//                register-file write-port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = '0;

  // One pending register-file write: held until the write port takes it
  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } out_reg_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wr_arbiter_if
//  Description : Writeback request, register-file write port and hazard query
//                bundle shared by the arbiter and its neighbours.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_wr_arbiter_if;
  import rf_pkg::*;

  // Execute unit writeback
  logic            req0_valid;
  logic [AW-1:0]   req0_rd;
  logic [XLEN-1:0] req0_data;
  logic            req0_ready;

  // Load unit writeback
  logic            req1_valid;
  logic [AW-1:0]   req1_rd;
  logic [XLEN-1:0] req1_data;
  logic            req1_ready;

  // Register file write port
  logic            rf_busy;
  logic            rf_regwr;
  logic [AW-1:0]   rf_rw;
  logic [XLEN-1:0] rf_busw;

  // Decode hazard lookup
  logic [AW-1:0]   qa;
  logic [AW-1:0]   qb;
  logic            hit_a;
  logic            hit_b;

  logic [15:0]     wr_count;

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    output req0_ready,
    input  req1_valid, req1_rd, req1_data,
    output req1_ready,
    input  rf_busy,
    output rf_regwr, rf_rw, rf_busw,
    input  qa, qb,
    output hit_a, hit_b,
    output wr_count
  );

  modport master (
    output req0_valid, req0_rd, req0_data,
    input  req0_ready,
    output req1_valid, req1_rd, req1_data,
    input  req1_ready,
    output rf_busy,
    input  rf_regwr, rf_rw, rf_busw,
    output qa, qb,
    input  hit_a, hit_b,
    input  wr_count
  );

endinterface : rf_wr_arbiter_if
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter. Under contention the requester
//                not granted last wins; grants are suppressed when disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  wire logic [1:0] valid,
  input  wire logic       last_grant,
  input  wire logic       en,
  output logic      [1:0] gnt,
  output logic            win
);

  // Pick a winner from the current valids, then qualify with enable
  always_comb begin
    win = 1'b0;
    gnt = 2'b00;
    case (valid)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_grant;
      default: win = 1'b0;
    endcase
    if (en && (valid != 2'b00)) begin
      gnt = win ? 2'b10 : 2'b01;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wr_arbiter
//  Description : Register-file write-port arbiter. Round-robins execute and
//                load writebacks into a one-entry output register driving the
//                file's write port, counts committed writes and answers
//                pending-write hazard queries from decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wr_arbiter
  import rf_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  rf_wr_arbiter_if.slave   bus
);

  out_reg_t        r_out;
  logic            r_last_grant;
  logic [15:0]     r_wr_count;

  logic            w_drain;
  logic            w_can_load;
  logic [1:0]      w_gnt;
  logic            w_win;
  logic            w_hs;
  logic [AW-1:0]   w_win_rd;
  logic [XLEN-1:0] w_win_data;

  // The entry leaves when the port is free; reset discards it unwritten
  assign w_drain    = r_out.valid & ~bus.rf_busy & ~rst;
  assign w_can_load = ~r_out.valid | ~bus.rf_busy;

  rr_arb2 u_arb (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (r_last_grant),
    .en         (w_can_load & ~rst),
    .gnt        (w_gnt),
    .win        (w_win)
  );

  assign bus.req0_ready = w_gnt[0];
  assign bus.req1_ready = w_gnt[1];
  assign w_hs           = |w_gnt;

  assign w_win_rd   = w_win ? bus.req1_rd   : bus.req0_rd;
  assign w_win_data = w_win ? bus.req1_data : bus.req0_data;

  // Output register, grant history and commit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out        <= '0;
      r_last_grant <= 1'b1;
      r_wr_count   <= '0;
    end else begin
      if (w_drain) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
      if (w_hs) begin
        r_last_grant <= w_win;
        if (w_win_rd != REG_ZERO) begin
          r_out.valid <= 1'b1;
          r_out.rd    <= w_win_rd;
          r_out.data  <= w_win_data;
        end else if (w_drain) begin
          r_out.valid <= 1'b0;
        end
      end else if (w_drain) begin
        r_out.valid <= 1'b0;
      end
    end
  end

  assign bus.rf_regwr = w_drain;
  assign bus.rf_rw    = r_out.rd;
  assign bus.rf_busw  = r_out.data;
  assign bus.wr_count = r_wr_count;

  // x0 is never a hazard since its writes are never loaded
  assign bus.hit_a = r_out.valid & (r_out.rd == bus.qa) & (bus.qa != REG_ZERO);
  assign bus.hit_b = r_out.valid & (r_out.rd == bus.qb) & (bus.qb != REG_ZERO);

endmodule : rf_wr_arbiter
`default_nettype wire

// File: tb/tb_rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_wr_arbiter
//  Description : Directed self-checking bench for rf_wr_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wr_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rf_wr_arbiter_if bus_if ();

  rf_wr_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive0(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus_if.req0_valid = v;
    bus_if.req0_rd    = rd;
    bus_if.req0_data  = d;
  endtask

  task automatic drive1(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus_if.req1_valid = v;
    bus_if.req1_rd    = rd;
    bus_if.req1_data  = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive0(1'b1, 5'd3, 32'h1);
    drive1(1'b1, 5'd4, 32'h2);
    bus_if.rf_busy = 1'b0;
    bus_if.qa = 5'd0;
    bus_if.qb = 5'd0;
    tick(); tick();

    // Reset state, with both requesters valid
    chk("rst_ready0", {31'd0, bus_if.req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, bus_if.req1_ready}, 32'd0);
    chk("rst_regwr",  {31'd0, bus_if.rf_regwr},   32'd0);
    chk("rst_rw",     {27'd0, bus_if.rf_rw},      32'd0);
    chk("rst_busw",   bus_if.rf_busw,             32'd0);
    chk("rst_count",  {16'd0, bus_if.wr_count},   32'd0);

    rst = 1'b0;
    drive0(1'b0, 5'd0, 32'h0);
    drive1(1'b0, 5'd0, 32'h0);
    tick();

    // Contention: req0, req1, req0, req1
    drive0(1'b1, 5'd1, 32'hAAAA_0001);
    drive1(1'b1, 5'd2, 32'hBBBB_0002);
    for (int k = 0; k < 4; k++) begin
      settle();
      if (k > 0) begin
        chk("cont_regwr", {31'd0, bus_if.rf_regwr}, 32'd1);
        chk("cont_rw", {27'd0, bus_if.rf_rw}, (k % 2 == 1) ? 32'd1 : 32'd2);
      end
      chk("cont_ready0", {31'd0, bus_if.req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_ready1", {31'd0, bus_if.req1_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
      tick();
    end
    drive0(1'b0, 5'd0, 32'h0);
    drive1(1'b0, 5'd0, 32'h0);
    settle();
    chk("cont_rw_last", {27'd0, bus_if.rf_rw}, 32'd2);
    chk("cont_busw_last", bus_if.rf_busw, 32'hBBBB_0002);
    tick();
    chk("cont_count", {16'd0, bus_if.wr_count}, 32'd4);

    // Single write
    drive0(1'b1, 5'd5, 32'hDEAD_BEEF);
    settle();
    chk("single_ready0", {31'd0, bus_if.req0_ready}, 32'd1);
    tick();
    drive0(1'b0, 5'd0, 32'h0);
    bus_if.qa = 5'd5;
    settle();
    chk("single_regwr", {31'd0, bus_if.rf_regwr}, 32'd1);
    chk("single_rw",    {27'd0, bus_if.rf_rw},    32'd5);
    chk("single_busw",  bus_if.rf_busw,           32'hDEAD_BEEF);
    chk("single_hit_a", {31'd0, bus_if.hit_a},    32'd1);
    tick();
    chk("single_count", {16'd0, bus_if.wr_count}, 32'd5);
    chk("single_idle",  {31'd0, bus_if.rf_regwr}, 32'd0);

    // x0 drop
    drive1(1'b1, 5'd0, 32'h1234);
    bus_if.qa = 5'd0;
    settle();
    chk("x0_ready1", {31'd0, bus_if.req1_ready}, 32'd1);
    tick();
    drive1(1'b0, 5'd0, 32'h0);
    settle();
    chk("x0_regwr", {31'd0, bus_if.rf_regwr}, 32'd0);
    chk("x0_hit_a", {31'd0, bus_if.hit_a},    32'd0);
    tick();
    chk("x0_count", {16'd0, bus_if.wr_count}, 32'd5);

    // Backpressure with an entry for rd=7 pending
    drive0(1'b1, 5'd7, 32'h0000_0077);
    settle();
    chk("bp_load_ready0", {31'd0, bus_if.req0_ready}, 32'd1);
    tick();
    drive0(1'b1, 5'd3, 32'h0000_0033);
    bus_if.rf_busy = 1'b1;
    bus_if.qa = 5'd7;
    bus_if.qb = 5'd3;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("bp_ready0", {31'd0, bus_if.req0_ready}, 32'd0);
      chk("bp_regwr",  {31'd0, bus_if.rf_regwr},   32'd0);
      chk("bp_hit_a",  {31'd0, bus_if.hit_a},      32'd1);
      chk("bp_hit_b",  {31'd0, bus_if.hit_b},      32'd0);
      tick();
    end
    bus_if.rf_busy = 1'b0;
    settle();
    chk("bp_commit_regwr", {31'd0, bus_if.rf_regwr}, 32'd1);
    chk("bp_commit_rw",    {27'd0, bus_if.rf_rw},    32'd7);
    chk("bp_commit_ready", {31'd0, bus_if.req0_ready}, 32'd1);
    tick();
    drive0(1'b0, 5'd0, 32'h0);
    settle();
    chk("bp_next_rw",    {27'd0, bus_if.rf_rw},      32'd3);
    chk("bp_next_count", {16'd0, bus_if.wr_count},   32'd6);
    chk("bp_next_hit_b", {31'd0, bus_if.hit_b},      32'd1);
    tick();
    chk("bp_done_count", {16'd0, bus_if.wr_count},   32'd7);

    // Busy with an empty output: one accept, then frozen
    bus_if.rf_busy = 1'b1;
    drive0(1'b1, 5'd4, 32'h0000_0044);
    settle();
    chk("bpe_ready0", {31'd0, bus_if.req0_ready}, 32'd1);
    tick();
    drive0(1'b1, 5'd6, 32'h0000_0066);
    bus_if.qa = 5'd4;
    settle();
    chk("bpe_frozen_ready0", {31'd0, bus_if.req0_ready}, 32'd0);
    chk("bpe_frozen_regwr",  {31'd0, bus_if.rf_regwr},   32'd0);
    chk("bpe_hit_a",         {31'd0, bus_if.hit_a},      32'd1);
    tick();
    bus_if.rf_busy = 1'b0;
    settle();
    chk("bpe_commit_rw", {27'd0, bus_if.rf_rw}, 32'd4);
    chk("bpe_ready0_free", {31'd0, bus_if.req0_ready}, 32'd1);
    tick();
    drive0(1'b0, 5'd0, 32'h0);
    settle();
    chk("bpe_next_rw", {27'd0, bus_if.rf_rw}, 32'd6);
    tick();
    chk("bpe_count", {16'd0, bus_if.wr_count}, 32'd9);

    // Reset mid-flight: last grant is req0 here, so reset must restore req0 priority
    drive0(1'b1, 5'd9, 32'h0000_0099);
    settle();
    chk("rmf_ready0", {31'd0, bus_if.req0_ready}, 32'd1);
    tick();
    drive0(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    bus_if.qa = 5'd9;
    settle();
    chk("rmf_regwr_in_rst", {31'd0, bus_if.rf_regwr}, 32'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("rmf_regwr", {31'd0, bus_if.rf_regwr}, 32'd0);
    chk("rmf_hit_a", {31'd0, bus_if.hit_a},    32'd0);
    chk("rmf_count", {16'd0, bus_if.wr_count}, 32'd0);
    drive0(1'b1, 5'd1, 32'h1);
    drive1(1'b1, 5'd2, 32'h2);
    settle();
    chk("rmf_cont_ready0", {31'd0, bus_if.req0_ready}, 32'd1);
    chk("rmf_cont_ready1", {31'd0, bus_if.req1_ready}, 32'd0);
    tick();
    drive0(1'b0, 5'd0, 32'h0);
    drive1(1'b0, 5'd0, 32'h0);
    tick();
    chk("rmf_first_count", {16'd0, bus_if.wr_count}, 32'd1);

    // Counter wrap: 65535 more back-to-back commits
    drive0(1'b1, 5'd1, 32'h5);
    for (int k = 0; k < 65535; k++) begin
      tick();
    end
    drive0(1'b0, 5'd0, 32'h0);
    settle();
    chk("wrap_pre", {16'd0, bus_if.wr_count}, 32'h0000_FFFF);
    tick();
    chk("wrap_zero", {16'd0, bus_if.wr_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rf_wr_arbiter
`default_nettype wire
